sc_regir_prefetch: RTL and testbench

Parametrised instruction register with an integrated prefetch queue. It buffers up to DEPTH fetched instruction words from the data bus and presents the current instruction as a register. That register drives two enabled bus outputs and decoded instruction-format fields (op, rd, op2, op3, rs1, bit13, rs2, simm13, disp22, disp30). It sits between the memory read path and the control unit of the microprogrammed datapath, replacing the single-entry IR.

---
 rtl/sc_regir_prefetch_if.sv | 51 +++++
 rtl/sc_regir_prefetch.sv | 132 +++++++++++++
 tb/tb_sc_regir_prefetch.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sc_regir_prefetch_if.sv
// Bus-side signal bundle of the prefetching instruction register.
// The master modport drives fetch/control, the slave modport is the IR block itself.
interface sc_regir_prefetch_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DEPTH         = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     SC_RegIR_Write_InHigh;
  logic                     SC_RegIR_Load_InHigh;
  logic                     SC_RegIR_Flush_InHigh;
  logic                     SC_RegIR_ENABLE_BUS_A;
  logic                     SC_RegIR_ENABLE_BUS_B;
  logic [DATAWIDTH_BUS-1:0] SC_RegIR_DataBUS_In;

  logic [DATAWIDTH_BUS-1:0] SC_RegIR_DataBUS_Out_A;
  logic [DATAWIDTH_BUS-1:0] SC_RegIR_DataBUS_Out_B;
  logic [1:0]               SC_RegIR_OP;
  logic [4:0]               SC_RegIR_RD;
  logic [2:0]               SC_RegIR_OP2;
  logic [5:0]               SC_RegIR_OP3;
  logic [4:0]               SC_RegIR_RS1;
  logic                     SC_RegIR_BIT13;
  logic [4:0]               SC_RegIR_RS2;
  logic [DATAWIDTH_BUS-1:0] SC_RegIR_SIMM13;
  logic [DATAWIDTH_BUS-1:0] SC_RegIR_DISP22;
  logic [DATAWIDTH_BUS-1:0] SC_RegIR_DISP30;
  logic                     SC_RegIR_Valid;
  logic [CW-1:0]            SC_RegIR_Count;
  logic                     SC_RegIR_Full;
  logic                     SC_RegIR_Empty;
  logic                     SC_RegIR_Overflow;

  modport master (
    output SC_RegIR_Write_InHigh, SC_RegIR_Load_InHigh, SC_RegIR_Flush_InHigh,
           SC_RegIR_ENABLE_BUS_A, SC_RegIR_ENABLE_BUS_B, SC_RegIR_DataBUS_In,
    input  SC_RegIR_DataBUS_Out_A, SC_RegIR_DataBUS_Out_B, SC_RegIR_OP, SC_RegIR_RD,
           SC_RegIR_OP2, SC_RegIR_OP3, SC_RegIR_RS1, SC_RegIR_BIT13, SC_RegIR_RS2,
           SC_RegIR_SIMM13, SC_RegIR_DISP22, SC_RegIR_DISP30, SC_RegIR_Valid,
           SC_RegIR_Count, SC_RegIR_Full, SC_RegIR_Empty, SC_RegIR_Overflow
  );

  modport slave (
    input  SC_RegIR_Write_InHigh, SC_RegIR_Load_InHigh, SC_RegIR_Flush_InHigh,
           SC_RegIR_ENABLE_BUS_A, SC_RegIR_ENABLE_BUS_B, SC_RegIR_DataBUS_In,
    output SC_RegIR_DataBUS_Out_A, SC_RegIR_DataBUS_Out_B, SC_RegIR_OP, SC_RegIR_RD,
           SC_RegIR_OP2, SC_RegIR_OP3, SC_RegIR_RS1, SC_RegIR_BIT13, SC_RegIR_RS2,
           SC_RegIR_SIMM13, SC_RegIR_DISP22, SC_RegIR_DISP30, SC_RegIR_Valid,
           SC_RegIR_Count, SC_RegIR_Full, SC_RegIR_Empty, SC_RegIR_Overflow
  );
endinterface

// File: rtl/sc_regir_prefetch.sv
// Instruction register fed by a DEPTH-entry circular prefetch queue.
// State changes on the falling clock edge; decode outputs follow IR combinationally.
module sc_regir_prefetch #(
  parameter int          DATAWIDTH_BUS    = 32,
  parameter int          DEPTH            = 4,
  parameter logic [31:0] DATA_REGGEN_INIT = 32'h00000000
) (
  input logic                SC_RegIR_CLOCK_50,
  input logic                SC_RegIR_Reset_InHigh,
  sc_regir_prefetch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATAWIDTH_BUS-1:0] IR_INIT = DATAWIDTH_BUS'(DATA_REGGEN_INIT);

  logic [DATAWIDTH_BUS-1:0] mem_q [DEPTH];
  logic [DATAWIDTH_BUS-1:0] ir_q, ir_d;
  logic [PW-1:0]            wptr_q, wptr_d;
  logic [PW-1:0]            rptr_q, rptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     valid_q, valid_d;
  logic                     ovf_q, ovf_d;
  logic                     push_s;
  logic                     full_s;
  logic                     empty_s;
  logic [31:0]              ir32_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == CW'(0));

  always_comb begin
    ir_d    = ir_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    push_s  = 1'b0;
    if (bus.SC_RegIR_Flush_InHigh) begin
      ir_d    = IR_INIT;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case ({bus.SC_RegIR_Write_InHigh, bus.SC_RegIR_Load_InHigh})
        2'b10: begin
          if (!full_s) begin
            push_s  = 1'b1;
            wptr_d  = wptr_q + PW'(1);
            count_d = count_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        2'b01: begin
          if (!empty_s) begin
            ir_d    = mem_q[rptr_q];
            rptr_d  = rptr_q + PW'(1);
            count_d = count_q - CW'(1);
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
        2'b11: begin
          // An empty queue forwards the bus word straight into IR; otherwise the
          // pop frees a slot (even when full), so the push always lands.
          if (empty_s) begin
            ir_d    = bus.SC_RegIR_DataBUS_In;
            valid_d = 1'b1;
          end else begin
            push_s  = 1'b1;
            ir_d    = mem_q[rptr_q];
            wptr_d  = wptr_q + PW'(1);
            rptr_d  = rptr_q + PW'(1);
            valid_d = 1'b1;
          end
        end
        default: begin
          ir_d = ir_q;
        end
      endcase
    end
  end

  always_ff @(negedge SC_RegIR_CLOCK_50 or posedge SC_RegIR_Reset_InHigh) begin
    if (SC_RegIR_Reset_InHigh) begin
      ir_q    <= IR_INIT;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Queue storage carries no reset: stale entries are never reachable through rptr.
  always_ff @(negedge SC_RegIR_CLOCK_50) begin
    if (push_s && !SC_RegIR_Reset_InHigh) begin
      mem_q[wptr_q] <= bus.SC_RegIR_DataBUS_In;
    end
  end

  assign ir32_s = ir_q[31:0];

  assign bus.SC_RegIR_DataBUS_Out_A = bus.SC_RegIR_ENABLE_BUS_A ? ir_q : '0;
  assign bus.SC_RegIR_DataBUS_Out_B = bus.SC_RegIR_ENABLE_BUS_B ? ir_q : '0;
  assign bus.SC_RegIR_OP     = ir32_s[31:30];
  assign bus.SC_RegIR_RD     = ir32_s[29:25];
  assign bus.SC_RegIR_OP2    = ir32_s[24:22];
  assign bus.SC_RegIR_OP3    = ir32_s[24:19];
  assign bus.SC_RegIR_RS1    = ir32_s[18:14];
  assign bus.SC_RegIR_BIT13  = ir32_s[13];
  assign bus.SC_RegIR_RS2    = ir32_s[4:0];
  assign bus.SC_RegIR_SIMM13 = {{(DATAWIDTH_BUS-13){ir32_s[12]}}, ir32_s[12:0]};
  assign bus.SC_RegIR_DISP22 = {{(DATAWIDTH_BUS-22){ir32_s[21]}}, ir32_s[21:0]};
  assign bus.SC_RegIR_DISP30 = {{(DATAWIDTH_BUS-30){ir32_s[29]}}, ir32_s[29:0]};
  assign bus.SC_RegIR_Valid    = valid_q;
  assign bus.SC_RegIR_Count    = count_q;
  assign bus.SC_RegIR_Full     = full_s;
  assign bus.SC_RegIR_Empty    = empty_s;
  assign bus.SC_RegIR_Overflow = ovf_q;
endmodule

// File: tb/tb_sc_regir_prefetch.sv
// Self-checking bench: queue-based reference model compared every rising edge,
// plus hand-computed expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_sc_regir_prefetch;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] INIT  = 32'h00000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_regir_prefetch_if #(.DATAWIDTH_BUS(DW), .DEPTH(DEPTH)) bus ();

  sc_regir_prefetch #(.DATAWIDTH_BUS(DW), .DEPTH(DEPTH), .DATA_REGGEN_INIT(INIT)) dut (
    .SC_RegIR_CLOCK_50    (clk),
    .SC_RegIR_Reset_InHigh(rst),
    .bus                  (bus.slave)
  );

  logic [31:0] m_q[$];
  logic [31:0] m_ir;
  bit          m_valid;
  bit          m_ovf;
  bit          cmp_en = 1'b0;
  int          tests  = 0;
  int          fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int b);
    logic [31:0] mask;
    mask = (32'h1 << b) - 32'h1;
    return v[b-1] ? (v | ~mask) : (v & mask);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ir    = INIT;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit w, input bit l, input bit f, input logic [31:0] d);
    int n0;
    if (f) begin
      model_reset();
    end else begin
      n0 = m_q.size();
      if (l) begin
        if (n0 > 0) begin
          m_ir = m_q.pop_front();
          m_valid = 1'b1;
        end else if (w) begin
          m_ir = d;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (w && !(l && n0 == 0)) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit w, input bit l, input bit f, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.SC_RegIR_Write_InHigh = w;
    bus.SC_RegIR_Load_InHigh  = l;
    bus.SC_RegIR_Flush_InHigh = f;
    bus.SC_RegIR_DataBUS_In   = d;
    @(negedge clk);
    model_step(w, l, f, d);
    #1;
  endtask

  // Continuous comparison of every output against the model
  initial begin
    forever begin
      @(posedge clk);
      if (cmp_en) begin
        chk("out_a", bus.SC_RegIR_DataBUS_Out_A, bus.SC_RegIR_ENABLE_BUS_A ? m_ir : 32'h0);
        chk("out_b", bus.SC_RegIR_DataBUS_Out_B, bus.SC_RegIR_ENABLE_BUS_B ? m_ir : 32'h0);
        chk("op",    bus.SC_RegIR_OP,    (m_ir >> 30) & 32'h3);
        chk("rd",    bus.SC_RegIR_RD,    (m_ir >> 25) & 32'h1F);
        chk("op2",   bus.SC_RegIR_OP2,   (m_ir >> 22) & 32'h7);
        chk("op3",   bus.SC_RegIR_OP3,   (m_ir >> 19) & 32'h3F);
        chk("rs1",   bus.SC_RegIR_RS1,   (m_ir >> 14) & 32'h1F);
        chk("bit13", bus.SC_RegIR_BIT13, (m_ir >> 13) & 32'h1);
        chk("rs2",   bus.SC_RegIR_RS2,   m_ir & 32'h1F);
        chk("simm13", bus.SC_RegIR_SIMM13, sx(m_ir, 13));
        chk("disp22", bus.SC_RegIR_DISP22, sx(m_ir, 22));
        chk("disp30", bus.SC_RegIR_DISP30, sx(m_ir, 30));
        chk("valid", bus.SC_RegIR_Valid, m_valid);
        chk("count", bus.SC_RegIR_Count, m_q.size());
        chk("full",  bus.SC_RegIR_Full,  m_q.size() == DEPTH);
        chk("empty", bus.SC_RegIR_Empty, m_q.size() == 0);
        chk("ovf",   bus.SC_RegIR_Overflow, m_ovf);
      end
    end
  end

  initial begin
    bus.SC_RegIR_Write_InHigh = 1'b0;
    bus.SC_RegIR_Load_InHigh  = 1'b0;
    bus.SC_RegIR_Flush_InHigh = 1'b0;
    bus.SC_RegIR_ENABLE_BUS_A = 1'b0;
    bus.SC_RegIR_ENABLE_BUS_B = 1'b0;
    bus.SC_RegIR_DataBUS_In   = 32'h0;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;

    // Reset state
    chk("rst_count", bus.SC_RegIR_Count, 0);
    chk("rst_empty", bus.SC_RegIR_Empty, 1);
    chk("rst_full",  bus.SC_RegIR_Full, 0);
    chk("rst_valid", bus.SC_RegIR_Valid, 0);
    chk("rst_outa",  bus.SC_RegIR_DataBUS_Out_A, 32'h0);
    chk("rst_outb",  bus.SC_RegIR_DataBUS_Out_B, 32'h0);
    bus.SC_RegIR_ENABLE_BUS_A = 1'b1;
    bus.SC_RegIR_ENABLE_BUS_B = 1'b1;
    #1;
    chk("rst_outa_en", bus.SC_RegIR_DataBUS_Out_A, INIT);

    // Three pushes then three loads; 8A00_6005 decodes to op=2 rd=5 op3=0 rs1=1 i=1 simm=5
    cyc(1, 0, 0, 32'h8A00_6005);
    cyc(1, 0, 0, 32'h8210_0001);
    cyc(1, 0, 0, 32'h1080_0003);
    chk("seq_count3", bus.SC_RegIR_Count, 3);
    cyc(0, 1, 0, 32'h0);
    chk("seq_ir0",   bus.SC_RegIR_DataBUS_Out_A, 32'h8A00_6005);
    chk("seq_op",    bus.SC_RegIR_OP, 2);
    chk("seq_rd",    bus.SC_RegIR_RD, 5);
    chk("seq_op3",   bus.SC_RegIR_OP3, 0);
    chk("seq_rs1",   bus.SC_RegIR_RS1, 1);
    chk("seq_bit13", bus.SC_RegIR_BIT13, 1);
    chk("seq_simm",  bus.SC_RegIR_SIMM13, 32'h5);
    chk("seq_count2", bus.SC_RegIR_Count, 2);
    chk("seq_valid", bus.SC_RegIR_Valid, 1);
    cyc(0, 1, 0, 32'h0);
    chk("seq_ir1", bus.SC_RegIR_DataBUS_Out_B, 32'h8210_0001);
    chk("seq_count1", bus.SC_RegIR_Count, 1);
    cyc(0, 1, 0, 32'h0);
    chk("seq_ir2", bus.SC_RegIR_DataBUS_Out_A, 32'h1080_0003);
    chk("seq_count0", bus.SC_RegIR_Count, 0);
    chk("seq_valid2", bus.SC_RegIR_Valid, 1);

    // Fill, overflow, write+load while full, drain
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'hA000_0000 + 32'(i));
    chk("fill_full", bus.SC_RegIR_Full, 1);
    cyc(1, 0, 0, 32'hDEAD_BEEF);
    chk("ovf_set",   bus.SC_RegIR_Overflow, 1);
    chk("ovf_count", bus.SC_RegIR_Count, 4);
    cyc(1, 1, 0, 32'hC0DE_0005);
    chk("wl_full_count", bus.SC_RegIR_Count, 4);
    chk("wl_full_ovf",   bus.SC_RegIR_Overflow, 1);
    chk("wl_full_ir",    bus.SC_RegIR_DataBUS_Out_A, 32'hA000_0000);
    for (int i = 1; i < 4; i++) begin
      cyc(0, 1, 0, 32'h0);
      chk("drain_ir", bus.SC_RegIR_DataBUS_Out_A, 32'hA000_0000 + 32'(i));
    end
    cyc(0, 1, 0, 32'h0);
    chk("drain_last", bus.SC_RegIR_DataBUS_Out_A, 32'hC0DE_0005);
    chk("drain_empty", bus.SC_RegIR_Empty, 1);

    // Bypass on empty queue
    cyc(1, 1, 0, 32'h8800_3FFF);
    chk("byp_ir",    bus.SC_RegIR_DataBUS_Out_A, 32'h8800_3FFF);
    chk("byp_count", bus.SC_RegIR_Count, 0);
    chk("byp_simm",  bus.SC_RegIR_SIMM13, 32'hFFFF_FFFF);
    chk("byp_valid", bus.SC_RegIR_Valid, 1);

    // Flush wins over concurrent write+load and clears the sticky overflow
    cyc(1, 0, 0, 32'h1111_1111);
    cyc(1, 0, 0, 32'h2222_2222);
    cyc(1, 1, 1, 32'h3333_3333);
    chk("fl_count", bus.SC_RegIR_Count, 0);
    chk("fl_ir",    bus.SC_RegIR_DataBUS_Out_A, INIT);
    chk("fl_valid", bus.SC_RegIR_Valid, 0);
    chk("fl_ovf",   bus.SC_RegIR_Overflow, 0);
    cyc(0, 1, 0, 32'h0);
    chk("bubble_valid", bus.SC_RegIR_Valid, 0);
    chk("bubble_ir",    bus.SC_RegIR_DataBUS_Out_A, INIT);

    // Asynchronous reset between edges with three words queued
    cyc(1, 0, 0, 32'h4444_0001);
    cyc(1, 1, 0, 32'h4444_0002);
    cyc(1, 0, 0, 32'h4444_0003);
    cyc(1, 0, 0, 32'h4444_0004);
    chk("pre_rst_count", bus.SC_RegIR_Count, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_count", bus.SC_RegIR_Count, 0);
    chk("arst_empty", bus.SC_RegIR_Empty, 1);
    chk("arst_valid", bus.SC_RegIR_Valid, 0);
    chk("arst_ir",    bus.SC_RegIR_DataBUS_Out_A, INIT);
    bus.SC_RegIR_Write_InHigh = 1'b0;
    bus.SC_RegIR_Load_InHigh  = 1'b0;
    #1 rst = 1'b0;

    // Six push/load pairs walk both pointers past the wrap point
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 32'h5500_0000 + 32'(i * 7));
      cyc(0, 1, 0, 32'h0);
      chk("wrap_ir", bus.SC_RegIR_DataBUS_Out_A, 32'h5500_0000 + 32'(i * 7));
      chk("wrap_count", bus.SC_RegIR_Count, 0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.SC_RegIR_ENABLE_BUS_A = 1'($urandom_range(0, 1));
      bus.SC_RegIR_ENABLE_BUS_B = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
          $urandom_range(0, 99) < 3, $urandom);
    end

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
